// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: opcodes, NOP encoding and controller state encoding shared by the front end
package pipeline_hazard_ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_IMM  = 7'b0010011;
    localparam logic [6:0] OP_I_LW   = 7'b0000011;
    localparam logic [6:0] OP_S      = 7'b0100011;
    localparam logic [6:0] OP_SB     = 7'b1100011;
    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    // bit 0: reads rs1, bit 1: reads rs2
    function automatic logic [1:0] rs_use(input logic [6:0] op);
        return (op == OP_R || op == OP_S || op == OP_SB) ? 2'b11 :
               (op == OP_I_IMM || op == OP_I_LW) ? 2'b01 : 2'b00;
    endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/IF-ID/ID-EX sequencing for load-use, data-memory stall and taken-branch flush
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      id_instr_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             id_branch_taken_i,
    input  logic             mem_stall_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [CNT_W-1:0] load_stall_cnt_o,
    output logic [CNT_W-1:0] mem_wait_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    logic [1:0] state, state_nxt;
    logic [1:0] use_rs;
    logic       hz, run, unused_instr_bits;
    assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:7]};
    // RUN and MEM_WAIT decode identically; MEM_WAIT only records that a stall is in progress
    always_comb begin
        use_rs        = rs_use(id_instr_i[6:0]);
        hz            = ex_memread_i && ex_rd_i != 5'd0 &&
                        ((use_rs[0] && ex_rd_i == id_instr_i[19:15]) ||
                         (use_rs[1] && ex_rd_i == id_instr_i[24:20]));
        run           = state != ST_INIT;
        pipe_hold_o   = run && mem_stall_i;
        idex_bubble_o = run && !mem_stall_i && hz;
        pc_write_o    = run && !mem_stall_i && !hz;
        ifid_write_o  = pc_write_o;
        ifid_flush_o  = pc_write_o && id_branch_taken_i;
        state_nxt     = (run && mem_stall_i) ? ST_MEM_WAIT : ST_RUN;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end
    sat_counter #(.W(CNT_W)) u_load_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc(idex_bubble_o), .cnt(load_stall_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc(pipe_hold_o), .cnt(mem_wait_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i(clk_i), .rst_i(rst_i), .inc(ifid_flush_o), .cnt(flush_cnt_o)
    );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random stimulus against a rule-level reference model
module tb_pipeline_hazard_ctrl;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [31:0]   id_instr_i = 32'h00000013;
    logic          ex_memread_i = 1'b0;
    logic [4:0]    ex_rd_i = 5'd0;
    logic          id_branch_taken_i = 1'b0;
    logic          mem_stall_i = 1'b0;
    logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_hold_o;
    logic [CW-1:0] load_stall_cnt_o, mem_wait_cnt_o, flush_cnt_o;
    int vectors = 0;
    int miscompares = 0;
    bit live = 0;
    int n_load = 0, n_wait = 0, n_flush = 0;
    bit e_pc, e_flush, e_bub, e_hold;
    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_instr_i(id_instr_i),
        .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
        .id_branch_taken_i(id_branch_taken_i), .mem_stall_i(mem_stall_i),
        .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .pipe_hold_o(pipe_hold_o),
        .load_stall_cnt_o(load_stall_cnt_o), .mem_wait_cnt_o(mem_wait_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic predict();
        logic [6:0] op;
        int used;
        bit hz;
        op   = id_instr_i[6:0];
        used = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) ? 2 :
               (op == 7'b0010011 || op == 7'b0000011) ? 1 : 0;
        hz   = ex_memread_i && ex_rd_i != 0 &&
               ((used >= 1 && ex_rd_i == id_instr_i[19:15]) ||
                (used == 2 && ex_rd_i == id_instr_i[24:20]));
        e_hold  = live && mem_stall_i;
        e_bub   = live && !mem_stall_i && hz;
        e_pc    = live && !mem_stall_i && !hz;
        e_flush = e_pc && id_branch_taken_i;
    endtask
    task automatic check_counters();
        check("load_stall_cnt", 32'(load_stall_cnt_o), n_load);
        check("mem_wait_cnt", 32'(mem_wait_cnt_o), n_wait);
        check("flush_cnt", 32'(flush_cnt_o), n_flush);
    endtask
    task automatic check_zero_outputs();
        check("rst pc_write", 32'(pc_write_o), 0);
        check("rst ifid_write", 32'(ifid_write_o), 0);
        check("rst flush", 32'(ifid_flush_o), 0);
        check("rst bubble", 32'(idex_bubble_o), 0);
        check("rst hold", 32'(pipe_hold_o), 0);
    endtask
    task automatic step(input logic [31:0] instr, input logic mr, input logic [4:0] rd,
                        input logic br, input logic ms);
        id_instr_i = instr; ex_memread_i = mr; ex_rd_i = rd;
        id_branch_taken_i = br; mem_stall_i = ms;
        #1;
        predict();
        check("pc_write", 32'(pc_write_o), 32'(e_pc));
        check("ifid_write", 32'(ifid_write_o), 32'(e_pc));
        check("ifid_flush", 32'(ifid_flush_o), 32'(e_flush));
        check("idex_bubble", 32'(idex_bubble_o), 32'(e_bub));
        check("pipe_hold", 32'(pipe_hold_o), 32'(e_hold));
        @(posedge clk_i);
        if (e_bub && n_load < CMAX) n_load++;
        if (e_hold && n_wait < CMAX) n_wait++;
        if (e_flush && n_flush < CMAX) n_flush++;
        live = 1;
        #1;
        check_counters();
    endtask
    task automatic apply_reset();
        rst_i = 1'b0;
        #1;
        live = 0; n_load = 0; n_wait = 0; n_flush = 0;
        check_zero_outputs();
        check_counters();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask
    localparam logic [31:0] ADD_X6_X5_X7  = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADDI_X6_X8_7  = {12'd7, 5'd8, 3'd0, 5'd6, 7'b0010011};
    localparam logic [31:0] BEQ_X1_X2     = {7'd0, 5'd2, 5'd1, 3'd0, 5'd8, 7'b1100011};
    logic [6:0] ops [7] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
                            7'b0000011, 7'b1101111, 7'b0110111};
    initial begin
        logic [31:0] instr;
        repeat (2) @(posedge clk_i);
        #1;
        apply_reset();
        step(32'h13, 0, 0, 0, 0);
        step(32'h13, 0, 0, 0, 0);
        step(32'h13, 0, 0, 0, 0);
        step(ADD_X6_X5_X7, 1, 5'd5, 0, 0);
        step(ADD_X6_X5_X7, 0, 5'd0, 0, 0);
        step(ADD_X6_X5_X7, 1, 5'd0, 0, 0);
        step(ADDI_X6_X8_7, 1, 5'd7, 0, 0);
        step(ADD_X6_X5_X7, 1, 5'd5, 1, 0);
        repeat (4) step(BEQ_X1_X2, 0, 0, 1, 1);
        step(BEQ_X1_X2, 0, 0, 1, 0);
        step(32'h13, 0, 0, 0, 0);
        step(32'h13, 0, 0, 0, 1);
        step(32'h13, 0, 0, 0, 1);
        apply_reset();
        step(32'h13, 0, 0, 0, 1);
        step(32'h13, 0, 0, 0, 0);
        repeat ((1 << CW) + 3) step(BEQ_X1_X2, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            instr        = $urandom;
            instr[6:0]   = ops[$urandom_range(0, 6)];
            instr[19:15] = 5'($urandom_range(0, 3));
            instr[24:20] = 5'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0)
                apply_reset();
            step(instr, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
